// File: rtl/neighbor_aggregator_if.sv
// Purpose: handshake/bus bundle for neighbor_aggregator (input beat stream + result stream).
// Ports: in_valid/in_ready/in_data/in_last carry neighbour beats; out_valid/out_ready/
//        out_data/out_count carry the summed vector; busy reports a group in progress.
interface neighbor_aggregator_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data [DEPTH-1:0];
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data [DEPTH-1:0];
  logic [CNT_W-1:0]        out_count;
  logic                    busy;

  // Aggregator side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, busy
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/neighbor_aggregator.sv
// Purpose: lane-wise sum of a variable-length group of DEPTH-lane feature vectors (GCN aggregation);
//          result plus neighbour count presented on a valid/ready output one cycle after in_last.
// Ports: clk, reset (async, active-high), bus (neighbor_aggregator_if.slave).
// Build option: define NEIGHBOR_AGG_SATURATE_EN for signed saturating lane adds (default: wraparound).
module neighbor_aggregator #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  neighbor_aggregator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                  state;
  logic signed [WIDTH-1:0] acc [DEPTH-1:0];
  logic [CNT_W-1:0]        count;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    accept;

  // In HOLD a new beat may only enter in the same cycle the result leaves.
  assign bus.in_ready = !reset && ((state != HOLD) || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_count = count;
  assign bus.out_data  = acc;

  function automatic logic signed [WIDTH-1:0] lane_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] s;
    s = a + b;
`ifdef NEIGHBOR_AGG_SATURATE_EN
    // Overflow only when both operands share a sign and the sum's sign differs.
    if ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1])) begin
      s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      case (state)
        // IDLE and HOLD share the fresh-load path; HOLD only accepts alongside out_ready.
        IDLE, HOLD: begin
          if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
              acc[i] <= bus.in_data[i];
            end
            count       <= CNT_ONE;
            state       <= bus.in_last ? HOLD : ACCUM;
            out_valid_q <= bus.in_last;
            busy_q      <= 1'b1;
          end else if ((state == HOLD) && bus.out_ready) begin
            // Result consumed with nothing behind it; acc/count keep their values.
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        ACCUM: begin
          if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
              acc[i] <= lane_add(acc[i], bus.in_data[i]);
            end
            if (count != CNT_MAX) begin
              count <= count + CNT_ONE;
            end
            if (bus.in_last) begin
              state       <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_aggregator.sv
// Purpose: self-checking bench for neighbor_aggregator against a behavioural sum/count model.
// Ports: none; drives the DUT through a neighbor_aggregator_if instance.
// Build option: NEIGHBOR_AGG_SATURATE_EN selects the saturating reference arithmetic.
module tb_neighbor_aggregator;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  typedef logic [63:0] vec_t [4];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neighbor_aggregator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  neighbor_aggregator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t exp_sum;
  int   exp_cnt = 0;
  bit   grp_open = 1'b0;

  // Reference lane add: exact integer sum, then wrap or clamp to the 64-bit signed range.
  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b);
    logic signed [65:0] s;
    logic signed [65:0] maxv;
    logic signed [65:0] minv;
    s    = 66'($signed(a)) + 66'($signed(b));
    maxv = 66'sd9223372036854775807;
    minv = -maxv - 66'sd1;
`ifdef NEIGHBOR_AGG_SATURATE_EN
    if (s > maxv) s = maxv;
    else if (s < minv) s = minv;
`endif
    return s[63:0];
  endfunction

  task automatic model_beat(input vec_t d, input bit last);
    if (!grp_open) begin
      exp_sum = d;
      exp_cnt = 1;
    end else begin
      for (int i = 0; i < 4; i++) exp_sum[i] = ref_add(exp_sum[i], d[i]);
      if (exp_cnt < CNT_SAT) exp_cnt++;
    end
    grp_open = !last;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_count"}, 64'(bus.out_count), 64'(exp_cnt));
    for (int i = 0; i < 4; i++) check($sformatf("%s_lane%0d", tag, i), bus.out_data[i], exp_sum[i]);
  endtask

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 4; i++) v[i] = {$urandom, $urandom};
    return v;
  endfunction

  // Present a beat from the falling edge, wait (bounded) for in_ready, then let it be taken.
  task automatic send(input vec_t d, input bit last);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) bus.in_data[i] = d[i];
    bus.in_last = last;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 50) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    model_beat(d, last);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_consumed_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_consumed_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vec_t v;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus.in_data[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.out_count), 64'd0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_lane%0d", i), bus.out_data[i], 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Directed 3-beat group
    send(mk(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
    send(mk(64'd10, 64'd20, 64'd30, 64'd40), 1'b0);
    send(mk(-64'sd5, 64'd0, 64'd5, 64'd100), 1'b1);
    idle();
    check_result("grp3");
    check("grp3_const0", bus.out_data[0], 64'd6);
    check("grp3_const1", bus.out_data[1], 64'd22);
    check("grp3_const2", bus.out_data[2], 64'd38);
    check("grp3_const3", bus.out_data[3], 64'd144);
    check("grp3_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    check("grp3_done_valid", 64'(bus.out_valid), 64'd0);
    check("grp3_done_busy", 64'(bus.busy), 64'd0);

    // Backpressure: result held while a new beat is offered and refused
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      v = rand_vec();
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 4; i++) bus.in_data[i] = v[i];
      #1;
      check($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
      check_result($sformatf("bp%0d", c));
    end
    consume("bp");

    // Back-to-back single-beat groups
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) check_result($sformatf("b2b%0d", k - 1));
      if (k < 8) begin
        v = rand_vec();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 4; i++) bus.in_data[i] = v[i];
        #1;
        check($sformatf("b2b%0d_in_ready", k), 64'(bus.in_ready), 64'd1);
        model_beat(v, 1'b1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("b2b_end_valid", 64'(bus.out_valid), 64'd0);

    // Random groups with random result stalls
    for (int g = 0; g < 6; g++) begin
      int len;
      len = $urandom_range(1, 5);
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int b = 0; b < len; b++) send(rand_vec(), b == len - 1);
      idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_result($sformatf("rnd%0d", g));
      consume($sformatf("rnd%0d", g));
    end

    // Lane overflow
    send(mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0), 1'b0);
    send(mk(64'd1, 64'd0, 64'd0, 64'd0), 1'b1);
    idle();
    check_result("ovf");
`ifdef NEIGHBOR_AGG_SATURATE_EN
    check("ovf_const", bus.out_data[0], 64'h7FFF_FFFF_FFFF_FFFF);
`else
    check("ovf_const", bus.out_data[0], 64'h8000_0000_0000_0000);
`endif
    consume("ovf");

    // Neighbour counter saturation
    for (int b = 0; b < CNT_SAT + 2; b++) send(mk(64'd1, 64'd1, 64'd1, 64'd1), b == CNT_SAT + 1);
    idle();
    check_result("cntsat");
    check("cntsat_const", 64'(bus.out_count), 64'(CNT_SAT));
    check("cntsat_lane", bus.out_data[0], 64'(CNT_SAT + 2));
    consume("cntsat");

    // Asynchronous reset mid-group
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    grp_open = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_count", 64'(bus.out_count), 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 4; i++) check($sformatf("mrst_lane%0d", i), bus.out_data[i], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(mk(64'd7, 64'd7, 64'd7, 64'd7), 1'b1);
    idle();
    check_result("post_rst");
    for (int i = 0; i < 4; i++) check($sformatf("post_rst_const%0d", i), bus.out_data[i], 64'd7);
    check("post_rst_count1", 64'(bus.out_count), 64'd1);
    consume("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
